// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch requester (i_*), load/store requester (d_*) and unified memory (m_*).
// The arbiter uses the slave view; the core plus memory side uses the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  m_req;
  logic                  m_we;
  logic [DATA_W/8-1:0]   m_be;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic                  m_gnt;
  logic                  m_rvalid;
  logic [DATA_W-1:0]     m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_gnt, m_rvalid, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_req, m_we, m_be, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_gnt, m_rvalid, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_req, m_we, m_be, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch (I) and load/store (D), one transaction at a time.
// Define ARB_ROUND_ROBIN_EN to alternate owners under contention instead of fixed D-over-I priority.
//
//   state | meaning
//   IDLE  | no transaction; sample requests and latch the owner
//   REQ   | owner's request presented to memory, waiting for m_gnt
//   RESP  | waiting for m_rvalid with the watchdog counting
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic              busy,
  output logic              err
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int BE_W = DATA_W / 8;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif

  logic [1:0]        state;
  logic              owner_d;
  logic              last_d;
  logic [15:0]       cnt;
  logic              pick_d;
  logic              own_req;
  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic [BE_W-1:0]   own_be;
  logic              tmo;

  always_comb begin
    // Under contention round-robin hands the bus to whoever did not complete last.
    pick_d    = bus.d_req & (!ROUND_ROBIN | !bus.i_req | !last_d);
    own_req   = owner_d ? bus.d_req : bus.i_req;
    own_we    = owner_d & bus.d_we;
    own_addr  = owner_d ? bus.d_addr : bus.i_addr;
    own_wdata = owner_d ? bus.d_wdata : '0;
    own_be    = owner_d ? bus.d_be : '1;
    tmo       = (cnt == TMO_LAST);
  end

  always_comb begin
    bus.m_req    = 1'b0;
    bus.m_we     = 1'b0;
    bus.m_be     = '0;
    bus.m_addr   = '0;
    bus.m_wdata  = '0;
    bus.i_gnt    = 1'b0;
    bus.d_gnt    = 1'b0;
    bus.i_rvalid = 1'b0;
    bus.d_rvalid = 1'b0;
    bus.i_rdata  = '0;
    bus.d_rdata  = '0;
    busy         = 1'b0;
    err          = 1'b0;
    // Gating on rst drops a response that coincides with reset.
    if (rst) begin
      busy = (state != S_IDLE);
      case (state)
        S_REQ: begin
          bus.m_req   = own_req;
          bus.m_we    = own_we;
          bus.m_be    = own_be;
          bus.m_addr  = own_addr;
          bus.m_wdata = own_wdata;
          bus.i_gnt   = !owner_d & own_req & bus.m_gnt;
          bus.d_gnt   =  owner_d & own_req & bus.m_gnt;
        end
        S_RESP: begin
          if (bus.m_rvalid || tmo) begin
            bus.i_rvalid = !owner_d;
            bus.d_rvalid = owner_d;
            bus.i_rdata  = (!owner_d && bus.m_rvalid) ? bus.m_rdata : '0;
            bus.d_rdata  = (owner_d && bus.m_rvalid) ? bus.m_rdata : '0;
            err          = !bus.m_rvalid;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      owner_d <= 1'b0;
      last_d  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_req || bus.d_req) begin
            owner_d <= pick_d;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (!own_req) begin
            state <= S_IDLE;
          end else if (bus.m_gnt) begin
            cnt   <= '0;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          cnt <= cnt + 16'd1;
          if (bus.m_rvalid) begin
            last_d <= owner_d;
            state  <= S_IDLE;
          end else if (tmo) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory bus between the core's instruction-fetch requester (I) and load/store requester (D).
- Sits between RV32I_core's fetch/LSU interfaces and the unified memory.
- One outstanding transaction at a time: request/grant handshake on each side, one response per transaction.
- Response watchdog aborts a hung access and flags an error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT, 255, max cycles in RESP before abort; legal range 1..2^16-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  ADDR_W  fetch address; stable while i_req.
- i_gnt  out  1  fetch accepted (1-cycle pulse).
- i_rvalid  out  1  fetch data valid (1-cycle pulse).
- i_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  DATA_W/8  byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data accepted (1-cycle pulse).
- d_rvalid  out  1  load data / store ack (1-cycle pulse).
- d_rdata  out  DATA_W  load data.
- m_req  out  1  memory request.
- m_we  out  1  memory write.
- m_be  out  DATA_W/8  memory byte enables.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_gnt  in  1  memory accepted request.
- m_rvalid  in  1  memory response, one per accepted request (reads and writes).
- m_rdata  in  DATA_W  memory read data.
- busy  out  1  state != IDLE.
- err  out  1  timeout abort (1-cycle pulse).

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, owner=I, last_owner=I, timeout counter 0. All outputs 0. Any in-flight memory response is dropped.
- States: IDLE, REQ, RESP.
- IDLE:
  - No request: stay.
  - Else latch owner: D if d_req, otherwise I (fixed priority, D over I). Go REQ next cycle.
  - m_rvalid ignored.
- REQ:
  - m_req = owner's req. m_addr/m_we/m_be/m_wdata are combinational from the owner.
  - Owner I drives m_we=0 and m_be=all ones.
  - m_gnt=1 and owner req=1: pulse owner's gnt in the same cycle (combinational), clear counter, go RESP.
  - Owner req=0: protocol abort, back to IDLE, no gnt.
  - m_rvalid ignored.
- RESP:
  - m_req=0. Counter increments each cycle.
  - m_rvalid=1: owner's rvalid=1 and owner's rdata=m_rdata that cycle; go IDLE; last_owner<=owner.
  - Counter reaches TIMEOUT with no m_rvalid: err=1, owner's rvalid=1 with rdata=0, go IDLE.
  - m_rvalid on the same cycle as the timeout: the response wins, err=0.
- Non-owner gnt/rvalid are always 0; rdata outputs are 0 when rvalid=0.
- Latency: IDLE->REQ is 1 cycle. With zero-wait memory (m_gnt and m_rvalid both immediate), req to rvalid is 3 cycles and back-to-back transactions issue every 3 cycles.
- New requests are not sampled in REQ or RESP; a request arriving there waits for IDLE.
- Both requesters pending in IDLE: D wins; I is served in the next IDLE cycle unless D is pending again. I can starve in the base build.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both i_req and d_req are 1 in IDLE, owner = the requester that is not last_owner (alternates). A single pending requester is served directly.
- Undefined: fixed D-over-I priority as above; last_owner is still maintained but unused.

Test Plan:
- Single fetch: i_req, i_addr=0x100, zero-wait memory, m_rdata=0x00500093 → m_addr=0x100, m_we=0, m_be=0xF; i_gnt in cycle 2; i_rvalid=1, i_rdata=0x00500093 in cycle 3; busy 1 for 2 cycles.
- Store: d_req, d_we=1, d_be=0x3, d_addr=0x2004, d_wdata=0xDEADBEEF, m_gnt delayed 2 cycles → m_req held for 3 cycles with those values; d_gnt pulses once, then d_rvalid once; i_* stay 0.
- Contention: i_req and d_req both held, 4 transactions each → base build order D,D,D,D,I,I,I,I. With ARB_ROUND_ROBIN_EN: D,I,D,I,D,I,D,I.
- Timeout: TIMEOUT=4, load granted, m_rvalid never returned → err and d_rvalid pulse on the 4th RESP cycle, d_rdata=0, then IDLE. A late m_rvalid in IDLE is ignored. Repeat with m_rvalid on exactly the 4th RESP cycle → err=0, data passed through.
- Reset mid-operation: rst=0 during RESP with m_rvalid in the same cycle → next cycle IDLE, no rvalid, all outputs 0. A new fetch after reset completes normally.
- Requester drop: d_req deasserted in REQ before m_gnt → no d_gnt, back to IDLE, m_req=0 the following cycle.
